// File: rtl/ysyx_23060124_exu_pkg.sv
// ysyx_23060124_exu_pkg: ALU op codes, branch funct3 codes and FSM state encoding for the execute stage
package ysyx_23060124_exu_pkg;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;
endpackage

// File: rtl/ysyx_23060124_exu_mul_iter.sv
// ysyx_23060124_exu_mul_iter: shift-add multiplier, one partial product per cycle; built only with YSYX_23060124_EXU_MUL_EN
`ifdef YSYX_23060124_EXU_MUL_EN
module ysyx_23060124_exu_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  logic            busy;
  logic [4:0]      cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  // The last partial product is folded in combinationally so done and product line up.
  assign done    = busy && cnt == 5'd0;
  assign product = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= 5'd0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= 5'(MUL_CYCLES - 1);
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 5'd1;
      busy   <= cnt != 5'd0;
    end
endmodule
`endif

// File: rtl/ysyx_23060124_exu_ctrl.sv
// ysyx_23060124_exu_ctrl: execute stage (ALU, branch/jump redirect, EX/LS output register)
// Define YSYX_23060124_EXU_MUL_EN to add the iterative multiplier and its MUL state.
module ysyx_23060124_exu_ctrl
  import ysyx_23060124_exu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_pre_valid,
  output logic            o_pre_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_alu_rs1,
  input  logic [XLEN-1:0] i_alu_rs2,
  input  logic [XLEN-1:0] i_agu_base,
  input  logic [XLEN-1:0] i_agu_off,
  input  logic [2:0]      i_exu_opt,
  input  logic            i_alt,
  input  logic            i_brch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic [2:0]      i_brch_opt,
  input  logic            i_mul,
  input  logic [4:0]      i_rd,
  input  logic            i_wen,
  input  logic            i_csr_wen,
  input  logic            i_mret,
  input  logic            i_ecall,
  input  logic            i_load,
  input  logic            i_store,
  input  logic [2:0]      i_load_opt,
  input  logic [2:0]      i_store_opt,
  output logic            o_post_valid,
  input  logic            i_post_ready,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_store_data,
  output logic [4:0]      o_rd,
  output logic            o_wen,
  output logic            o_csr_wen,
  output logic            o_mret,
  output logic            o_ecall,
  output logic            o_load,
  output logic            o_store,
  output logic [2:0]      o_load_opt,
  output logic [2:0]      o_store_opt,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc
);
  state_t          state, state_nxt;
  logic            accept, mul_start, mul_done, capture, taken, redir, lt, ltu;
  logic [4:0]      shamt;
  logic [XLEN-1:0] sum, sra, alu, target, link, res, mul_prod;

  assign o_pre_ready = state == ST_IDLE && (!o_post_valid || i_post_ready);
  assign accept      = i_pre_valid && o_pre_ready;
  assign capture     = (accept && !mul_start) || mul_done;

`ifdef YSYX_23060124_EXU_MUL_EN
  assign mul_start = accept && i_mul;
  ysyx_23060124_exu_mul_iter #(
    .XLEN      (XLEN),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_start),
    .a      (i_alu_rs1),
    .b      (i_alu_rs2),
    .done   (mul_done),
    .product(mul_prod)
  );
`else
  logic unused_mul;
  assign mul_start  = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_prod   = '0;
  assign unused_mul = i_mul ^ (MUL_CYCLES == 0);
`endif

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (mul_start) state_nxt = ST_MUL;
    else if (mul_done) state_nxt = ST_IDLE;
  end

  assign shamt = i_alu_rs2[4:0];
  assign sum   = i_alt ? i_alu_rs1 - i_alu_rs2 : i_alu_rs1 + i_alu_rs2;
  assign sra   = $signed(i_alu_rs1) >>> shamt;
  assign lt    = $signed(i_alu_rs1) < $signed(i_alu_rs2);
  assign ltu   = i_alu_rs1 < i_alu_rs2;

  always_comb begin
    alu = sum;
    case (i_exu_opt)
      ALU_SLL:  alu = i_alu_rs1 << shamt;
      ALU_SLT:  alu = XLEN'(lt);
      ALU_SLTU: alu = XLEN'(ltu);
      ALU_XOR:  alu = i_alu_rs1 ^ i_alu_rs2;
      ALU_SRL:  alu = i_alt ? sra : i_alu_rs1 >> shamt;
      ALU_OR:   alu = i_alu_rs1 | i_alu_rs2;
      ALU_AND:  alu = i_alu_rs1 & i_alu_rs2;
      default:  alu = sum;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (i_brch_opt)
      BR_EQ:   taken = i_alu_rs1 == i_alu_rs2;
      BR_NE:   taken = i_alu_rs1 != i_alu_rs2;
      BR_LT:   taken = lt;
      BR_GE:   taken = !lt;
      BR_LTU:  taken = ltu;
      BR_GEU:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  assign target = i_agu_base + i_agu_off;
  assign link   = i_pc + XLEN'(4);
  assign redir  = (i_brch && taken) || i_jal || i_jalr;
  assign res    = (i_jal || i_jalr) ? link : alu;

  // Side-band fields load at accept; a MUL bundle only gets its result when the multiplier finishes.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      o_post_valid  <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_result      <= '0;
      o_store_data  <= '0;
      o_rd          <= 5'd0;
      o_wen         <= 1'b0;
      o_csr_wen     <= 1'b0;
      o_mret        <= 1'b0;
      o_ecall       <= 1'b0;
      o_load        <= 1'b0;
      o_store       <= 1'b0;
      o_load_opt    <= 3'd0;
      o_store_opt   <= 3'd0;
    end else begin
      o_post_valid <= capture || (o_post_valid && !i_post_ready);
      o_redirect   <= accept && !mul_start && redir;
      if (capture) o_result <= mul_done ? mul_prod : res;
      if (accept) begin
        o_redirect_pc <= i_jalr ? {target[XLEN-1:1], 1'b0} : target;
        o_store_data  <= i_alu_rs2;
        o_rd          <= i_rd;
        o_wen         <= i_wen;
        o_csr_wen     <= i_csr_wen;
        o_mret        <= i_mret;
        o_ecall       <= i_ecall;
        o_load        <= i_load;
        o_store       <= i_store;
        o_load_opt    <= i_load_opt;
        o_store_opt   <= i_store_opt;
      end
    end
endmodule
